// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter
// Purpose  : Shares one SDRAM controller port between NUM_MASTERS requesters
//            (port 0 read cache, port 1 write buffer, port 2 display fetch).
//            Only one transaction is in flight at a time. Read burst beats
//            are steered back to the master that issued the read.
// Config   : SDRAM_ARB_RR_EN defined   -> round-robin arbitration starting
//                                         at rr_ptr, wrapping N-1 -> 0.
//            SDRAM_ARB_RR_EN undefined -> fixed priority, lowest index wins.
// Ports    : clk, reset (async, active-high)
//            m_*     : per-master request/accept/write/address/data/mask in,
//                      per-master rvalid/complete out, shared rdata/raddress
//            sdram_* : single controller-side request/ready/write/address/
//                      data/mask out, rvalid/raddress/rdata/complete in
// Revision : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 26
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_MASTERS-1:0]    m_request,
    output logic [NUM_MASTERS-1:0]    m_ready,
    input  logic [NUM_MASTERS-1:0]    m_write,
    input  logic [NUM_MASTERS*AW-1:0] m_address,
    input  logic [NUM_MASTERS*32-1:0] m_wdata,
    input  logic [NUM_MASTERS*4-1:0]  m_wmask,
    output logic [NUM_MASTERS-1:0]    m_rvalid,
    output logic [NUM_MASTERS-1:0]    m_complete,
    output logic [31:0]               m_rdata,
    output logic [AW-1:0]             m_raddress,
    output logic                      sdram_request,
    input  logic                      sdram_ready,
    output logic                      sdram_write,
    output logic [AW-1:0]             sdram_address,
    output logic [31:0]               sdram_wdata,
    output logic [3:0]                sdram_wmask,
    input  logic                      sdram_rvalid,
    input  logic [AW-1:0]             sdram_raddress,
    input  logic [31:0]               sdram_rdata,
    input  logic                      sdram_complete
);

    localparam int c_GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_READ_WAIT = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [c_GW-1:0]          r_grant;
    logic [c_GW-1:0]          w_pick;
    logic                     w_any;
    logic                     w_latch_grant;
    logic [NUM_MASTERS-1:0]   w_grant_oh;

    logic                     w_sel_write;
    logic [AW-1:0]            w_sel_address;
    logic [31:0]              w_sel_wdata;
    logic [3:0]               w_sel_wmask;

    // Read data and address are shared; only rvalid/complete are steered.
    assign m_rdata    = sdram_rdata;
    assign m_raddress = sdram_raddress;

    assign w_any = |m_request;

`ifdef SDRAM_ARB_RR_EN
    logic [c_GW-1:0] r_rr_ptr;
    logic [c_GW-1:0] w_grant_inc;
    logic            w_txn_done;
    int              w_rr_idx;
    logic            w_rr_found;

    // Round-robin: walk from rr_ptr upward, wrapping, first requester wins.
    always_comb begin
        w_pick     = '0;
        w_rr_idx   = 0;
        w_rr_found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_rr_idx = int'(r_rr_ptr) + k;
            if (w_rr_idx >= NUM_MASTERS) begin
                w_rr_idx = w_rr_idx - NUM_MASTERS;
            end
            if (!w_rr_found && m_request[w_rr_idx]) begin
                w_pick     = c_GW'(w_rr_idx);
                w_rr_found = 1'b1;
            end
        end
    end

    assign w_grant_inc = (r_grant == c_GW'(NUM_MASTERS - 1)) ? '0 : r_grant + c_GW'(1);

    // A transaction ends on write acceptance or on the last read beat.
    assign w_txn_done = ((r_state == S_ISSUE) && sdram_ready && w_sel_write) ||
                        ((r_state == S_READ_WAIT) && sdram_rvalid && sdram_complete);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_txn_done) begin
            r_rr_ptr <= w_grant_inc;
        end
    end
`else
    // Fixed priority: scan downward so the lowest requesting index is kept.
    always_comb begin
        w_pick = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (m_request[i]) begin
                w_pick = c_GW'(i);
            end
        end
    end
`endif

    always_comb begin
        w_grant_oh = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant == c_GW'(i)) begin
                w_grant_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_write   = 1'b0;
        w_sel_address = '0;
        w_sel_wdata   = '0;
        w_sel_wmask   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_grant_oh[i]) begin
                w_sel_write   = m_write[i];
                w_sel_address = m_address[i*AW +: AW];
                w_sel_wdata   = m_wdata[i*32 +: 32];
                w_sel_wmask   = m_wmask[i*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant <= '0;
        end else if (w_latch_grant) begin
            r_grant <= w_pick;
        end
    end

    // Controller-side fields are gated to zero outside ISSUE so that idle
    // and reset present an all-zero request bus.
    always_comb begin
        w_state_next  = r_state;
        w_latch_grant = 1'b0;
        sdram_request = 1'b0;
        sdram_write   = 1'b0;
        sdram_address = '0;
        sdram_wdata   = '0;
        sdram_wmask   = '0;
        m_ready       = '0;
        m_rvalid      = '0;
        m_complete    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_latch_grant = 1'b1;
                    w_state_next  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                sdram_request = 1'b1;
                sdram_write   = w_sel_write;
                sdram_address = w_sel_address;
                sdram_wdata   = w_sel_wdata;
                sdram_wmask   = w_sel_wmask;
                if (sdram_ready) begin
                    m_ready      = w_grant_oh;
                    w_state_next = w_sel_write ? S_IDLE : S_READ_WAIT;
                end
            end
            S_READ_WAIT: begin
                if (sdram_rvalid) begin
                    m_rvalid = w_grant_oh;
                    if (sdram_complete) begin
                        m_complete   = w_grant_oh;
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_arbiter
// Purpose  : Self-checking bench for sdram_arbiter (3 masters, AW=26).
//            Table-driven write-with-wait vectors plus hand sequences for
//            reset, arbitration order, read bursts, stray rvalid and reset
//            in the middle of a burst. Honours SDRAM_ARB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

    localparam int N  = 3;
    localparam int AW = 26;

    logic          clk;
    logic          reset;
    logic [N-1:0]  m_request;
    logic [N-1:0]  m_ready;
    logic [N-1:0]  m_write;
    logic [N*AW-1:0] m_address;
    logic [N*32-1:0] m_wdata;
    logic [N*4-1:0]  m_wmask;
    logic [N-1:0]  m_rvalid;
    logic [N-1:0]  m_complete;
    logic [31:0]   m_rdata;
    logic [AW-1:0] m_raddress;
    logic          sdram_request;
    logic          sdram_ready;
    logic          sdram_write;
    logic [AW-1:0] sdram_address;
    logic [31:0]   sdram_wdata;
    logic [3:0]    sdram_wmask;
    logic          sdram_rvalid;
    logic [AW-1:0] sdram_raddress;
    logic [31:0]   sdram_rdata;
    logic          sdram_complete;

    sdram_arbiter #(.NUM_MASTERS(N), .AW(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .m_request      (m_request),
        .m_ready        (m_ready),
        .m_write        (m_write),
        .m_address      (m_address),
        .m_wdata        (m_wdata),
        .m_wmask        (m_wmask),
        .m_rvalid       (m_rvalid),
        .m_complete     (m_complete),
        .m_rdata        (m_rdata),
        .m_raddress     (m_raddress),
        .sdram_request  (sdram_request),
        .sdram_ready    (sdram_ready),
        .sdram_write    (sdram_write),
        .sdram_address  (sdram_address),
        .sdram_wdata    (sdram_wdata),
        .sdram_wmask    (sdram_wmask),
        .sdram_rvalid   (sdram_rvalid),
        .sdram_raddress (sdram_raddress),
        .sdram_rdata    (sdram_rdata),
        .sdram_complete (sdram_complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_master(input int i, input logic wr, input logic [AW-1:0] a,
                              input logic [31:0] d, input logic [3:0] m);
        m_write[i]           = wr;
        m_address[i*AW +: AW] = a;
        m_wdata[i*32 +: 32]   = d;
        m_wmask[i*4 +: 4]     = m;
    endtask

    typedef struct {
        logic [N-1:0]  req;
        logic          ready;
        logic          exp_req;
        logic [N-1:0]  exp_mready;
        logic          exp_write;
        logic [AW-1:0] exp_addr;
        logic [31:0]   exp_wdata;
        logic [3:0]    exp_wmask;
    } vec_t;

    vec_t vecs[6];
    int   exp_g[4];
    int   ready_cnt;
    int   rvalid_cnt;

    initial begin
        // Write by master 1 with the controller stalling for 3 cycles.
        vecs[0] = '{3'b010, 1'b0, 1'b0, 3'b000, 1'b0, 26'h0,   32'h0,        4'h0};
        vecs[1] = '{3'b010, 1'b0, 1'b1, 3'b000, 1'b1, 26'h100, 32'hDEADBEEF, 4'hF};
        vecs[2] = '{3'b010, 1'b0, 1'b1, 3'b000, 1'b1, 26'h100, 32'hDEADBEEF, 4'hF};
        vecs[3] = '{3'b010, 1'b0, 1'b1, 3'b000, 1'b1, 26'h100, 32'hDEADBEEF, 4'hF};
        vecs[4] = '{3'b010, 1'b1, 1'b1, 3'b010, 1'b1, 26'h100, 32'hDEADBEEF, 4'hF};
        vecs[5] = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 26'h0,   32'h0,        4'h0};
`ifdef SDRAM_ARB_RR_EN
        exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 2; exp_g[3] = 0;
`else
        exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 0; exp_g[3] = 0;
`endif

        // ---------------- reset with all masters requesting ----------------
        reset          = 1'b1;
        m_request      = 3'b111;
        m_write        = '0;
        m_address      = '0;
        m_wdata        = '0;
        m_wmask        = '0;
        sdram_ready    = 1'b0;
        sdram_rvalid   = 1'b0;
        sdram_raddress = '0;
        sdram_rdata    = '0;
        sdram_complete = 1'b0;
        set_master(0, 1'b1, 26'h111, 32'h1111_0000, 4'h1);
        set_master(1, 1'b1, 26'h222, 32'h2222_0000, 4'h3);
        set_master(2, 1'b1, 26'h333, 32'h3333_0000, 4'h7);

        @(negedge clk); #1;
        chk("rst_sdram_request", sdram_request, 0);
        chk("rst_sdram_write",   sdram_write,   0);
        chk("rst_sdram_address", sdram_address, 0);
        chk("rst_sdram_wdata",   sdram_wdata,   0);
        chk("rst_sdram_wmask",   sdram_wmask,   0);
        chk("rst_m_ready",       m_ready,       0);
        chk("rst_m_rvalid",      m_rvalid,      0);
        chk("rst_m_complete",    m_complete,    0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("release_idle_req", sdram_request, 0);

        // ---------------- arbitration order, all requesting ----------------
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            sdram_ready = 1'b1;
            #1;
            chk("arb_sdram_request", sdram_request, 1);
            chk("arb_grant_m_ready", m_ready, 3'b001 << exp_g[k]);
            chk("arb_sdram_address", sdram_address, 26'h111 * (exp_g[k] + 1));
            @(negedge clk);
            sdram_ready = 1'b0;
            if (k == 3) m_request = 3'b000;
            #1;
            chk("arb_idle_between", sdram_request, 0);
            chk("arb_idle_m_ready", m_ready, 0);
        end

        // ---------------- table: write with 3 wait cycles ----------------
        set_master(1, 1'b1, 26'h100, 32'hDEADBEEF, 4'hF);
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            m_request   = vecs[v].req;
            sdram_ready = vecs[v].ready;
            #1;
            chk("wr_sdram_request", sdram_request, vecs[v].exp_req);
            chk("wr_m_ready",       m_ready,       vecs[v].exp_mready);
            chk("wr_sdram_write",   sdram_write,   vecs[v].exp_write);
            chk("wr_sdram_address", sdram_address, vecs[v].exp_addr);
            chk("wr_sdram_wdata",   sdram_wdata,   vecs[v].exp_wdata);
            chk("wr_sdram_wmask",   sdram_wmask,   vecs[v].exp_wmask);
        end

        // ---------------- master 0 16-beat read ----------------
        ready_cnt  = 0;
        rvalid_cnt = 0;
        set_master(0, 1'b0, 26'h000040, 32'h0, 4'h0);
        @(negedge clk);
        m_request = 3'b001;
        #1;
        chk("rd_idle_req", sdram_request, 0);
        @(negedge clk);
        sdram_ready = 1'b1;
        #1;
        chk("rd_issue_req",   sdram_request, 1);
        chk("rd_issue_write", sdram_write,   0);
        chk("rd_issue_addr",  sdram_address, 26'h000040);
        chk("rd_m_ready",     m_ready,       3'b001);
        ready_cnt += int'(m_ready[0]);
        @(negedge clk);
        sdram_ready = 1'b0;
        m_request   = 3'b000;
        #1;
        chk("rd_wait_no_rvalid", m_rvalid, 0);
        ready_cnt += int'(m_ready[0]);
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            sdram_rvalid   = 1'b1;
            sdram_rdata    = 32'hA000_0000 + 32'(b);
            sdram_raddress = 26'h000040 + 26'(b);
            sdram_complete = (b == 15);
            #1;
            chk("rd_m_rvalid",   m_rvalid,   3'b001);
            chk("rd_m_complete", m_complete, (b == 15) ? 3'b001 : 3'b000);
            chk("rd_m_rdata",    m_rdata,    32'hA000_0000 + 32'(b));
            chk("rd_m_raddress", m_raddress, 26'h000040 + 26'(b));
            rvalid_cnt += int'(m_rvalid[0]);
            ready_cnt  += int'(m_ready[0]);
        end
        @(negedge clk);
        sdram_rvalid   = 1'b0;
        sdram_complete = 1'b0;
        #1;
        chk("rd_done_idle",   sdram_request, 0);
        chk("rd_done_rvalid", m_rvalid,      0);
        chk("rd_rvalid_count", 64'(rvalid_cnt), 16);
        chk("rd_ready_pulses", 64'(ready_cnt),  1);

        // ---------------- stray rvalid while idle ----------------
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            sdram_rvalid   = 1'b1;
            sdram_complete = 1'b1;
            #1;
            chk("stray_m_rvalid",   m_rvalid,      0);
            chk("stray_m_complete", m_complete,    0);
            chk("stray_sdram_req",  sdram_request, 0);
        end
        @(negedge clk);
        sdram_rvalid   = 1'b0;
        sdram_complete = 1'b0;

        // ---------------- reset in the middle of a burst ----------------
        set_master(2, 1'b0, 26'h000200, 32'h0, 4'h0);
        m_request = 3'b100;
        #1;
        chk("mid_idle_req", sdram_request, 0);
        @(negedge clk);
        sdram_ready = 1'b1;
        #1;
        chk("mid_issue_req",  sdram_request, 1);
        chk("mid_m_ready",    m_ready,       3'b100);
        chk("mid_issue_addr", sdram_address, 26'h000200);
        @(negedge clk);
        sdram_ready = 1'b0;
        m_request   = 3'b000;
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            sdram_rvalid = 1'b1;
            sdram_rdata  = 32'hB000_0000 + 32'(b);
            #1;
            chk("mid_m_rvalid", m_rvalid, 3'b100);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_rvalid", m_rvalid,      0);
        chk("mid_rst_req",    sdram_request, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int b = 6; b < 16; b++) begin
            sdram_complete = (b == 15);
            #1;
            chk("drop_m_rvalid",   m_rvalid,      0);
            chk("drop_m_complete", m_complete,    0);
            chk("drop_sdram_req",  sdram_request, 0);
            @(negedge clk);
        end
        sdram_rvalid   = 1'b0;
        sdram_complete = 1'b0;

        // New transaction still served after the mid-burst reset.
        m_request = 3'b010;
        #1;
        chk("post_idle_req", sdram_request, 0);
        @(negedge clk);
        sdram_ready = 1'b1;
        #1;
        chk("post_issue_req", sdram_request, 1);
        chk("post_m_ready",   m_ready,       3'b010);
        @(negedge clk);
        sdram_ready = 1'b0;
        m_request   = 3'b000;
        #1;
        chk("post_back_idle", sdram_request, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
